seq_detect_sched: RTL and testbench
===================================

// Module: seq_detect_sched
// PURPOSE
//  Round-robin scheduler sharing one serial "00"/"11" sequence detector between N_REQ requesters.
//  - Accepts a parallel word from the granted requester, clears the detector, and shifts the word
//    onto the detector DATA line LSB first.
//  - Counts the detector's "00" (OUT=01) and "11" (OUT=10) reports.
//  - Returns both counts with the requester ID over a valid/ready response port.
//  - Sits between the requesting logic and the shared detector instance.
// PARAMETERS
//  N_REQ    4  number of requesters (>=2)
//  WORD_W   8  bits per request word, shifted LSB first
//  CNT_W    4  width of each match counter; counts saturate at 2**CNT_W-1
//  DET_LAT  2  cycles from a bit on DET_DATA to its result on DET_OUT (>=1)
// PORTS
//  CLK        in   1              clock, all logic on posedge
//  RST        in   1              synchronous, active-high reset
//  REQ_VALID  in   N_REQ          per-requester request valid
//  REQ_DATA   in   N_REQ*WORD_W   request words; requester i at [i*WORD_W +: WORD_W]
//  REQ_READY  out  N_REQ          one-hot accept; request i transfers when REQ_VALID[i]&REQ_READY[i]
//  DET_RST    out  1              clear to shared detector
//  DET_DATA   out  1              serial bit to shared detector
//  DET_OUT    in   2              detector result: 00 none, 01 "00" seen, 10 "11" seen, 11 illegal
//  RSP_VALID  out  1              response valid
//  RSP_READY  in   1              response accept
//  RSP_ID     out  $clog2(N_REQ)  index of the served requester
//  RSP_CNT00  out  CNT_W          number of DET_OUT==01 reports
//  RSP_CNT11  out  CNT_W          number of DET_OUT==10 reports
// BEHAVIOUR
//  Reset values (state held while RST=1):
//  - state=IDLE; REQ_READY=0; RSP_VALID=0; RSP_ID/RSP_CNT00/RSP_CNT11=0; DET_DATA=0; DET_RST=1.
//  - Round-robin pointer=N_REQ-1, so requester 0 has top priority first.
//  FSM: IDLE -> CLR -> SHIFT -> DRAIN -> RESP -> IDLE.
//  - IDLE: if any REQ_VALID, grant g = first valid index after the pointer (wrapping).
//    - REQ_READY[g]=1 combinationally in that cycle only; all other bits 0.
//    - Latch REQ_DATA[g], RSP_ID<=g, pointer<=g; next state CLR.
//    - No valid requests: stay in IDLE, REQ_READY=0.
//  - CLR (1 cycle): DET_RST=1, DET_DATA=0, both counters<=0.
//  - SHIFT (WORD_W cycles, c=0..WORD_W-1): DET_DATA=word[c], DET_RST=0.
//  - DRAIN (DET_LAT cycles): DET_DATA=0, DET_RST=0.
//  - Count window: DET_OUT sampled in the WORD_W cycles from SHIFT cycle c=DET_LAT through the
//    last DRAIN cycle; sample k is the result for bit k.
//    - If DET_LAT>=WORD_W, the window lies entirely inside DRAIN, at DRAIN cycles
//      DET_LAT-WORD_W .. DET_LAT-1.
//    - 01 increments CNT00; 10 increments CNT11; 00 and 11 are ignored (11 counts nothing).
//    - Both counters saturate at all-ones, with no wrap.
//  - RESP: RSP_VALID=1; RSP_ID/CNT00/CNT11 held stable until RSP_VALID&RSP_READY.
//    - On that handshake: RSP_VALID<=0, next state IDLE.
//    - The next grant comes at the earliest in the following cycle; no grant in RESP.
//  Latency: grant handshake in cycle T -> RSP_VALID first high in cycle T+2+WORD_W+DET_LAT.
//  Fairness: any continuously requesting requester is served within N_REQ transactions.
//  Request changes:
//  - REQ_VALID/REQ_DATA changes after the grant cycle have no effect on the transaction in flight.
//  - Dropping REQ_VALID before a grant is permitted, with no grant issued.
//  Reset mid-operation (any state):
//  - Abort the transaction; return to reset values next cycle.
//  - No response is issued for the aborted word.
//  - Pointer returns to N_REQ-1.
//  DET_RST = RST | (state==CLR).
// TESTING (default params; bench detector model with DET_LAT=2)
//  1 REQ_VALID=0001, word 8'h00 -> REQ_READY=0001 one cycle; RSP_VALID 12 cycles later,
//    ID=0, CNT00=7, CNT11=0.
//  2 word 8'hFF -> CNT00=0, CNT11=7.
//  3 word 8'h55 -> 0/0.
//  4 word 8'h33 -> CNT00=2, CNT11=2.
//  5 REQ_VALID=1111 held, RSP_READY=1 -> grants in order 0,1,2,3,0, each one-hot, one per
//    transaction.
//  6 RSP_READY=0 for 5 cycles in RESP -> RSP_* stable, REQ_READY=0; after accept, the next grant
//    comes the following cycle.
//  7 RST=1 during SHIFT cycle c=3 -> next cycle IDLE, all outputs at reset values, no response.
//    Subsequent REQ_VALID=1010 -> grant to requester 1.
//  8 CNT_W=2 with 8'h00 -> CNT00 saturates at 3.

Source files
------------

// File: rtl/seq_detect_sched.sv
// seq_detect_sched
//   Round-robin scheduler that shares one serial "00"/"11" sequence detector
//   between N_REQ requesters. A granted word is shifted LSB first onto the
//   detector after a one-cycle clear. The detector's "00" and "11" reports
//   are counted, and the counts are returned with the requester ID over a
//   valid/ready response port.
//
// Ports
//   CLK, RST     clock; synchronous active-high reset
//   REQ_VALID    per-requester request valid
//   REQ_DATA     request words, requester i at [i*WORD_W +: WORD_W]
//   REQ_READY    one-hot accept, asserted only in the grant cycle
//   DET_RST      clear to the shared detector (RST or CLR state)
//   DET_DATA     serial bit to the shared detector
//   DET_OUT      detector result: 00 none, 01 "00", 10 "11", 11 illegal
//   RSP_VALID    response valid, held until RSP_READY
//   RSP_READY    response accept
//   RSP_ID       index of the served requester
//   RSP_CNT00    saturating count of DET_OUT==01 reports
//   RSP_CNT11    saturating count of DET_OUT==10 reports
module seq_detect_sched #(
    parameter int N_REQ   = 4,
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          REQ_VALID,
    input  logic [N_REQ*WORD_W-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]          REQ_READY,
    output logic                      DET_RST,
    output logic                      DET_DATA,
    input  logic [1:0]                DET_OUT,
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [$clog2(N_REQ)-1:0]  RSP_ID,
    output logic [CNT_W-1:0]          RSP_CNT00,
    output logic [CNT_W-1:0]          RSP_CNT11
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int T_LAST = WORD_W + DET_LAT - 1;
    localparam int T_W    = $clog2(WORD_W + DET_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [WORD_W-1:0]  r_word;
    logic [T_W-1:0]     r_t;
    logic [CNT_W-1:0]   r_cnt00;
    logic [CNT_W-1:0]   r_cnt11;

    logic               w_grant_ok;
    logic [ID_W-1:0]    w_grant;
    logic [WORD_W-1:0]  w_sel_word;
    int unsigned        w_dist;
    int unsigned        w_best;

    // Round-robin pick: rank each valid requester by its distance past the
    // pointer (ptr+1 ranks 0, ptr itself ranks N_REQ-1) and keep the nearest.
    always_comb begin
        w_grant_ok = 1'b0;
        w_grant    = '0;
        w_best     = N_REQ;
        w_dist     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_dist = (i + 32'(N_REQ) - 1 - 32'(r_ptr)) % 32'(N_REQ);
            if (REQ_VALID[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_grant    = ID_W'(i);
                w_grant_ok = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_word = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_word = REQ_DATA[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_grant_ok) w_next = S_CLR;
            S_CLR:   w_next = S_SHIFT;
            S_SHIFT: if (r_t == T_W'(WORD_W - 1)) w_next = S_DRAIN;
            S_DRAIN: if (r_t == T_W'(T_LAST)) w_next = S_RESP;
            S_RESP:  if (RSP_READY) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are gated with RST so the reset values show during the reset
    // cycle itself, not only after the synchronous reset has taken effect.
    always_comb begin
        REQ_READY = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            REQ_READY[i] = !RST && (r_state == S_IDLE) && w_grant_ok &&
                           (w_grant == ID_W'(i));
        end
        DET_RST   = RST || (r_state == S_CLR);
        DET_DATA  = !RST && (r_state == S_SHIFT) && r_word[0];
        RSP_VALID = !RST && (r_state == S_RESP);
        RSP_ID    = r_id;
        RSP_CNT00 = r_cnt00;
        RSP_CNT11 = r_cnt11;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_ptr   <= ID_W'(N_REQ - 1);
            r_id    <= '0;
            r_word  <= '0;
            r_t     <= '0;
            r_cnt00 <= '0;
            r_cnt11 <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant_ok) begin
                        r_ptr  <= w_grant;
                        r_id   <= w_grant;
                        r_word <= w_sel_word;
                    end
                end
                S_CLR: begin
                    r_cnt00 <= '0;
                    r_cnt11 <= '0;
                    r_t     <= '0;
                end
                S_SHIFT, S_DRAIN: begin
                    // r_t runs across SHIFT and DRAIN; the result for bit k
                    // arrives at r_t == k + DET_LAT, so the window is r_t >= DET_LAT.
                    r_t <= r_t + 1'b1;
                    if (r_state == S_SHIFT) begin
                        r_word <= r_word >> 1;
                    end
                    if (r_t >= T_W'(DET_LAT)) begin
                        if ((DET_OUT == 2'b01) && (r_cnt00 != '1)) begin
                            r_cnt00 <= r_cnt00 + 1'b1;
                        end
                        if ((DET_OUT == 2'b10) && (r_cnt11 != '1)) begin
                            r_cnt11 <= r_cnt11 + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
module tb_seq_detect_sched;

    localparam int N_REQ   = 4;
    localparam int WORD_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_W2  = 2;
    localparam int DET_LAT = 2;
    localparam int ID_W    = $clog2(N_REQ);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [WORD_W-1:0]        req_word [N_REQ];
    logic [N_REQ*WORD_W-1:0]  req_data;
    logic                     rsp_ready = 1'b0;

    logic [N_REQ-1:0]         req_ready, req_ready2;
    logic                     det_rst, det_rst2, det_data, det_data2;
    logic [1:0]               det_out;
    logic                     rsp_valid, rsp_valid2;
    logic [ID_W-1:0]          rsp_id, rsp_id2;
    logic [CNT_W-1:0]         rsp_c00, rsp_c11;
    logic [CNT_W2-1:0]        rsp2_c00, rsp2_c11;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pack
        assign req_data[gi*WORD_W +: WORD_W] = req_word[gi];
    end

    seq_detect_sched #(.N_REQ(N_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W), .DET_LAT(DET_LAT)) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
        .REQ_READY(req_ready), .DET_RST(det_rst), .DET_DATA(det_data), .DET_OUT(det_out),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
        .RSP_CNT00(rsp_c00), .RSP_CNT11(rsp_c11)
    );

    // Narrow-counter copy, fed the same detector results, for saturation.
    seq_detect_sched #(.N_REQ(N_REQ), .WORD_W(WORD_W), .CNT_W(CNT_W2), .DET_LAT(DET_LAT)) dut2 (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
        .REQ_READY(req_ready2), .DET_RST(det_rst2), .DET_DATA(det_data2), .DET_OUT(det_out),
        .RSP_VALID(rsp_valid2), .RSP_READY(rsp_ready), .RSP_ID(rsp_id2),
        .RSP_CNT00(rsp2_c00), .RSP_CNT11(rsp2_c11)
    );

    // ---------------- shared detector model ----------------
    logic [1:0] det_pipe [DET_LAT];
    logic       det_prev, det_pv;

    // "None" results are sometimes reported as the illegal code 11,
    // which must never be counted.
    function automatic logic [1:0] det_res(input logic pv, input logic prev, input logic b);
        if (pv && (prev == b)) return b ? 2'b10 : 2'b01;
        return ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
    endfunction

    always @(posedge clk) begin
        if (det_rst) begin
            det_pv <= 1'b0;
            det_prev <= 1'b0;
            for (int i = 0; i < DET_LAT; i++) det_pipe[i] <= 2'b00;
        end else begin
            det_pipe[0] <= det_res(det_pv, det_prev, det_data);
            for (int i = 1; i < DET_LAT; i++) det_pipe[i] <= det_pipe[i-1];
            det_prev <= det_data;
            det_pv   <= 1'b1;
        end
    end
    assign det_out = det_pipe[DET_LAT-1];

    // ---------------- reference model helpers ----------------
    function automatic int pick(input int ptr, input logic [N_REQ-1:0] v);
        for (int i = 1; i <= N_REQ; i++) begin
            if (v[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    // Count adjacent equal bit pairs in the word (overlapping).
    function automatic void ref_counts(input logic [WORD_W-1:0] w, output int c00, output int c11);
        c00 = 0;
        c11 = 0;
        for (int k = 1; k < WORD_W; k++) begin
            if (w[k] == w[k-1]) begin
                if (w[k]) c11++;
                else      c00++;
            end
        end
    endfunction

    function automatic int sat(input int v, input int bits);
        return (v > (1 << bits) - 1) ? (1 << bits) - 1 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int id;
        int c00;
        int c11;
        int t;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    bit   m_busy   = 1'b0;
    int   m_ptr    = N_REQ - 1;
    bit   rsp_seen = 1'b0;
    bit   prev_rst = 1'b0;
    int   h_id, h_c00, h_c11;

    always @(negedge clk) begin
        exp_t e;
        int g, c00, c11;
        logic [N_REQ-1:0] exp_rdy;
        cyc++;
        if (prev_rst) begin
            check("rst_rsp_id", int'(rsp_id), 0);
            check("rst_cnt00", int'(rsp_c00), 0);
            check("rst_cnt11", int'(rsp_c11), 0);
        end
        if (rst) begin
            check("rst_req_ready", int'(req_ready), 0);
            check("rst_det_rst", int'(det_rst), 1);
            check("rst_det_data", int'(det_data), 0);
            check("rst_rsp_valid", int'(rsp_valid), 0);
            q.delete();
            m_busy   = 1'b0;
            m_ptr    = N_REQ - 1;
            rsp_seen = 1'b0;
        end else begin
            exp_rdy = '0;
            if (!m_busy && (req_valid != '0)) begin
                g = pick(m_ptr, req_valid);
                exp_rdy[g] = 1'b1;
                ref_counts(req_word[g], c00, c11);
                q.push_back('{g, c00, c11, cyc});
                m_busy = 1'b1;
                m_ptr  = g;
            end
            check("req_ready", int'(req_ready), int'(exp_rdy));
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", int'(rsp_valid), 0);
                end else begin
                    e = q[0];
                    if (!rsp_seen) begin
                        check("latency", cyc - e.t, 2 + WORD_W + DET_LAT);
                        rsp_seen = 1'b1;
                        h_id  = int'(rsp_id);
                        h_c00 = int'(rsp_c00);
                        h_c11 = int'(rsp_c11);
                    end else begin
                        check("stall_id", int'(rsp_id), h_id);
                        check("stall_cnt00", int'(rsp_c00), h_c00);
                        check("stall_cnt11", int'(rsp_c11), h_c11);
                    end
                    if (rsp_ready) begin
                        check("rsp_id", int'(rsp_id), e.id);
                        check("rsp_cnt00", int'(rsp_c00), sat(e.c00, CNT_W));
                        check("rsp_cnt11", int'(rsp_c11), sat(e.c11, CNT_W));
                        check("rsp_valid_w2", int'(rsp_valid2), 1);
                        check("sat_cnt00_w2", int'(rsp2_c00), sat(e.c00, CNT_W2));
                        check("sat_cnt11_w2", int'(rsp2_c11), sat(e.c11, CNT_W2));
                        void'(q.pop_front());
                        m_busy   = 1'b0;
                        rsp_seen = 1'b0;
                    end
                end
            end
        end
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input bit v, input string name);
        for (int n = 0; n < 200 && m_busy != v; n++) tick();
        check(name, int'(m_busy), int'(v));
    endtask

    task automatic serve(input logic [WORD_W-1:0] w);
        req_word[0] = w;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b1;
        wait_busy(1'b1, "grant_timeout");
        req_valid = '0;
        wait_busy(1'b0, "rsp_timeout");
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        case ($urandom_range(0, 2))
            0:       return WORD_W'($urandom);
            1:       return WORD_W'($urandom & $urandom & $urandom);
            default: return WORD_W'($urandom | $urandom | $urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < N_REQ; i++) req_word[i] = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        serve(8'h00);
        serve(8'hFF);
        serve(8'h55);
        serve(8'h33);

        // All requesting from a fresh pointer: grants 0,1,2,3,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) req_word[i] = rand_word();
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_busy(1'b1, "rr_grant_timeout");
            wait_busy(1'b0, "rr_rsp_timeout");
        end

        // Response back-pressure, then the next grant on the following cycle.
        rsp_ready = 1'b0;
        wait_busy(1'b1, "bp_grant_timeout");
        for (int n = 0; n < 200 && !rsp_valid; n++) tick();
        check("bp_rsp_valid", int'(rsp_valid), 1);
        repeat (5) tick();
        rsp_ready = 1'b1;
        wait_busy(1'b0, "bp_rsp_timeout");
        wait_busy(1'b1, "bp_next_grant");
        req_valid = '0;
        wait_busy(1'b0, "bp_drain");

        // Reset during SHIFT cycle c=3, then a 1010 request.
        req_word[0] = 8'hA5;
        req_valid   = 4'b0001;
        wait_busy(1'b1, "abort_grant_timeout");
        req_valid = '0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_word[1] = 8'h0F;
        req_valid   = 4'b1010;
        wait_busy(1'b1, "post_rst_grant");
        req_valid = '0;
        wait_busy(1'b0, "post_rst_rsp");

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            req_valid = N_REQ'($urandom);
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 3) == 0) req_word[i] = rand_word();
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_busy(1'b0, "final_drain");
        check("final_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
